// File: rtl/regbank_pkg.sv
// Shared defaults, FSM state encoding and byte-lane helper for the register bank writer.
package regbank_pkg;

    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned DW_DEF   = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    function automatic int unsigned nbytes(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/reg_bank_writer_dec_onehot.sv
// AW-to-NOUT one-hot decoder with enable; output is all-zero when disabled.
module dec_onehot #(
    parameter int unsigned AW   = 5,
    parameter int unsigned NOUT = 32
) (
    input  logic            en_i,
    input  logic [AW-1:0]   addr_i,
    output logic [NOUT-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_writer.sv
// Register file write side: byte-enabled handshaked write port plus a one-register-per-cycle clear sweep.
module reg_bank_writer
    import regbank_pkg::*;
#(
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic [DW/8-1:0]     wr_be,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    output logic [NREG-1:0]     wr_onehot,
    output logic [NREG*DW-1:0]  q_flat
);

    localparam int unsigned NB = nbytes(DW);

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            wr_fire;
    logic            sweep_en;
    logic [NREG-1:0] wr_dec;
    logic [NREG-1:0] clr_strobe;

    assign wr_ready = (state_q == ST_IDLE) && !rst;
    assign wr_fire  = wr_valid && wr_ready;
    assign sweep_en = (state_q == ST_SWEEP);
    assign clr_busy = busy_q;
    assign clr_done = done_q;

    dec_onehot #(.AW(AW), .NOUT(NREG)) u_wr_dec (
        .en_i     (wr_fire),
        .addr_i   (wr_addr),
        .onehot_o (wr_dec)
    );

    // Sweep clear reuses the decoder: the counter selects which register to zero.
    dec_onehot #(.AW(AW), .NOUT(NREG)) u_clr_dec (
        .en_i     (sweep_en),
        .addr_i   (cnt_q),
        .onehot_o (clr_strobe)
    );

    always_comb begin
        wr_onehot = wr_dec;
        if (ZERO_REG != 0) begin
            wr_onehot[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (cnt_q == AW'(NREG - 1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : gen_reg
        logic [DW-1:0] r_q;
        logic [DW-1:0] r_d;

        always_comb begin
            r_d = r_q;
            for (int unsigned k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    r_d[8*k +: 8] = wr_data[8*k +: 8];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst || clr_strobe[g]) begin
                r_q <= '0;
            end else if (wr_onehot[g]) begin
                r_q <= r_d;
            end
        end

        assign q_flat[g*DW +: DW] = (ZERO_REG != 0 && g == 0) ? '0 : r_q;
    end

endmodule

// File: tb/tb_reg_bank_writer.sv
// Self-checking bench for reg_bank_writer: directed scenarios plus random traffic against an array model.
module tb_reg_bank_writer;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_valid;
    logic                wr_ready;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [DW/8-1:0]     wr_be;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;
    logic [NREG-1:0]     wr_onehot;
    logic [NREG*DW-1:0]  q_flat;

    reg_bank_writer #(.NREG(NREG), .AW(AW), .DW(DW), .ZERO_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .wr_onehot (wr_onehot),
        .q_flat    (q_flat)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: register contents, sweep progress, done flag.
    logic [31:0] mdl [NREG];
    bit          m_sweep = 0;
    int          m_idx   = 0;
    bit          m_done  = 0;
    bit          chk_en  = 0;
    int          done_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] qreg(input int i);
        return q_flat[32*i +: 32];
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            foreach (mdl[i]) mdl[i] = '0;
            m_sweep = 0;
            m_idx   = 0;
            m_done  = 0;
            chk_en  = 1;
        end else if (chk_en) begin
            m_done = 0;
            if (!m_sweep) begin
                if (wr_valid && wr_addr != 0)
                    for (int k = 0; k < 4; k++)
                        if (wr_be[k]) mdl[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
                if (clr_req) begin
                    m_sweep = 1;
                    m_idx   = 0;
                end
            end else begin
                mdl[m_idx] = '0;
                if (m_idx == NREG - 1) begin
                    m_sweep = 0;
                    m_done  = 1;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic        exp_rdy;
            logic [31:0] exp_oh;
            exp_rdy = !m_sweep && !rst;
            exp_oh  = '0;
            if (wr_valid && exp_rdy && wr_addr != 0) exp_oh[wr_addr] = 1'b1;
            check("wr_ready", 32'(wr_ready), 32'(exp_rdy));
            check("clr_busy", 32'(clr_busy), 32'(m_sweep));
            check("clr_done", 32'(clr_done), 32'(m_done));
            check("wr_onehot", wr_onehot, exp_oh);
            for (int i = 0; i < NREG; i++) check($sformatf("q[%0d]", i), qreg(i), mdl[i]);
            if (clr_done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int a, input logic [31:0] d, input logic [3:0] be, input bit c);
        wr_valid = v;
        wr_addr  = AW'(a);
        wr_data  = d;
        wr_be    = be;
        clr_req  = c;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (wr_ready !== 1'b1 && n < 40) begin
            n++;
            tick();
        end
        if (n >= 40) check("wait_idle_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        logic [31:0] hold;
        // T1 reset with random inputs
        rst = 1'b1;
        drive(1'($urandom), int'($urandom_range(0, 31)), $urandom, 4'($urandom), 1'($urandom));
        #1;
        check("t1_ready_in_rst", 32'(wr_ready), 32'd0);
        tick();
        drive(1'($urandom), int'($urandom_range(0, 31)), $urandom, 4'($urandom), 1'($urandom));
        tick();
        check("t1_ready_in_rst2", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        idle();
        #1;
        check("t1_ready_after", 32'(wr_ready), 32'd1);
        for (int i = 0; i < NREG; i++) check("t1_q_zero", qreg(i), 32'd0);
        tick();

        // T2 write latency
        drive(1, 5, 32'hDEADBEEF, 4'hF, 0);
        tick();
        idle();
        check("t2_reg5", q_flat[191:160], 32'hDEADBEEF);
        check("t2_reg4", qreg(4), 32'd0);
        check("t2_reg6", qreg(6), 32'd0);

        // T3 byte enables
        drive(1, 7, 32'h11223344, 4'hF, 0);
        tick();
        drive(1, 7, 32'hAABBCCDD, 4'b0101, 0);
        tick();
        idle();
        check("t3_reg7", qreg(7), 32'h11BB33DD);
        check("t3_model7", mdl[7], 32'h11BB33DD);
        drive(1, 7, 32'h0, 4'h0, 0);
        tick();
        idle();
        check("t3_be0_noop", qreg(7), 32'h11BB33DD);

        // T4 zero register
        drive(1, 0, 32'hFFFFFFFF, 4'hF, 0);
        #1;
        check("t4_ready", 32'(wr_ready), 32'd1);
        check("t4_onehot", wr_onehot, 32'd0);
        tick();
        idle();
        check("t4_reg0", qreg(0), 32'd0);

        // T5 fill then sweep with a held write
        for (int i = 0; i < NREG; i++) begin
            drive(1, i, 32'(i + 1), 4'hF, 0);
            tick();
        end
        check("t5_reg31_fill", qreg(31), 32'd32);
        hold = 32'hCAFE0010;
        drive(1, 10, hold, 4'hF, 1);
        d0 = done_cnt;
        tick();
        clr_req = 1'b0;
        wait_idle(n);
        check("t5_stall_cycles", 32'(n), 32'd32);
        check("t5_done_now", 32'(clr_done), 32'd1);
        for (int i = 0; i < NREG; i++) check("t5_cleared", qreg(i), 32'd0);
        tick();
        idle();
        check("t5_held_write", qreg(10), hold);
        check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
        tick();

        // T6 write collides with clr_req, then reset mid-sweep
        drive(1, 3, 32'd9, 4'hF, 1);
        tick();
        idle();
        check("t6_write_lands", qreg(3), 32'd9);
        wait_idle(n);
        check("t6_reg3_swept", qreg(3), 32'd0);
        drive(1, 4, 32'h1234, 4'hF, 0);
        tick();
        drive(0, 0, '0, '0, 1);
        tick();
        idle();
        d0 = done_cnt;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_busy_after_rst", 32'(clr_busy), 32'd0);
        check("t6_ready_after_rst", 32'(wr_ready), 32'd1);
        check("t6_reg4_after_rst", qreg(4), 32'd0);
        repeat (40) tick();
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)), $urandom,
                  4'($urandom), $urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
